control_fsm: RTL and testbench

- Multi-cycle control unit for the 16-bit core.
- Consumes the 4-bit opcode and the compare result produced by the instruction execution system.
- Sequences fetch, immediate fetch, decode, execute, memory and writeback.
- Drives every datapath control strobe (register read/write, ALU select, CR write, RA backup/restore), plus PC/IR/ImR load enables and a request/ready memory handshake.

---
 rtl/control_fsm_pkg.sv | 51 +++++
 rtl/control_fsm_if.sv | 10 +
 rtl/control_fsm_mem_wait_timer.sv | 38 +++
 rtl/control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_control_fsm.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/control_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// writeback/PC source selects and the ALU add function.
package control_fsm_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_JAL  = 4'hB;
  localparam logic [3:0] OP_JR   = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hD;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_FETCH_IMM,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_CMP,
    S_BR,
    S_HLT
  } state_e;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_IMM = 2'b01;
  localparam logic [1:0] PC_RA  = 2'b10;

  localparam logic [1:0] RS_ALU = 2'b00;
  localparam logic [1:0] RS_IO  = 2'b01;
  localparam logic [1:0] RS_IMM = 2'b10;
  localparam logic [1:0] RS_MEM = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;

  // ADDI..JAL are followed by an immediate word in instruction memory.
  function automatic logic has_imm(input logic [3:0] opc);
    return (opc >= OP_ADDI) && (opc <= OP_JAL);
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Request/ready memory handshake between the control unit and memory.
interface control_fsm_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/control_fsm_mem_wait_timer.sv
// Counts cycles a memory request stays unanswered; flags the cycle in which
// the count would reach MEM_WAIT_MAX.
module mem_wait_timer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ready,
  input  logic clr,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_WAIT_MAX - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr || (req && ready)) begin
      count_d = '0;
    end else if (req) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign timeout = req && !ready && (count_q == LAST);

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 16-bit core: sequences fetch, immediate
// fetch, decode, execute, memory and writeback, driving every datapath strobe.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           op,
  input  logic                 cmp_result,
  control_fsm_if.master        mem,
  output logic                 PCWrite,
  output logic [1:0]           PCsrc,
  output logic                 IRWrite,
  output logic                 ImRWrite,
  output logic                 RegR1,
  output logic                 RegR2,
  output logic                 RegW1,
  output logic                 RegW2,
  output logic [1:0]           Regsrc,
  output logic                 ALUsrc,
  output logic [2:0]           ALUop,
  output logic                 writeCR,
  output logic                 cmpeq,
  output logic                 cmpne,
  output logic                 backup,
  output logic                 restore,
  output logic                 ioWrite,
  output logic                 halted,
  output logic                 fault
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       fault_q, fault_d;
  logic       req_state;
  logic       timer_clr;
  logic       timeout;

  // Request phase derived from the state alone so the timer does not loop
  // back through the output process.
  assign req_state = (state_q == S_FETCH) || (state_q == S_FETCH_IMM) || (state_q == S_MEM);
  assign timer_clr = (state_q == S_RST) || (state_q == S_HLT);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (reset),
    .req    (req_state),
    .ready  (mem.mem_ready),
    .clr    (timer_clr),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      op_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    fault_d      = fault_q;
    PCWrite      = 1'b0;
    PCsrc        = PC_INC;
    IRWrite      = 1'b0;
    ImRWrite     = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.iord     = 1'b0;
    RegR1        = 1'b0;
    RegR2        = 1'b0;
    RegW1        = 1'b0;
    RegW2        = 1'b0;
    Regsrc       = RS_ALU;
    ALUsrc       = 1'b0;
    ALUop        = ALU_ADD;
    writeCR      = 1'b0;
    cmpeq        = 1'b0;
    cmpne        = 1'b0;
    backup       = 1'b0;
    restore      = 1'b0;
    ioWrite      = 1'b0;
    halted       = 1'b0;
    fault        = fault_q;

    unique case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH, S_FETCH_IMM: begin
        mem.mem_req = 1'b1;
        if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HLT;
        end else if (mem.mem_ready) begin
          PCWrite = 1'b1;
          PCsrc   = PC_INC;
          if (state_q == S_FETCH) begin
            IRWrite = 1'b1;
            state_d = has_imm(op) ? S_FETCH_IMM : S_DECODE;
          end else begin
            ImRWrite = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        RegR1 = 1'b1;
        RegR2 = 1'b1;
        op_d  = op;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
          OP_ADDI, OP_LW, OP_SW:               state_d = S_EXEC;
          OP_BEQ, OP_BNE:                      state_d = S_CMP;
          OP_LI, OP_JAL, OP_IN, OP_OUT:        state_d = S_WB;
          OP_JR:                               state_d = S_BR;
          default:                             state_d = S_HLT;
        endcase
      end

      S_EXEC: begin
        if ((op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW)) begin
          ALUsrc = 1'b1;
          ALUop  = ALU_ADD;
        end else begin
          ALUop  = op_q[2:0];
        end
        state_d = ((op_q == OP_LW) || (op_q == OP_SW)) ? S_MEM : S_WB;
      end

      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_we  = (op_q == OP_SW);
        if (timeout) begin
          fault_d = 1'b1;
          state_d = S_HLT;
        end else if (mem.mem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end
      end

      S_WB: begin
        case (op_q)
          OP_LI:  begin RegW1 = 1'b1; Regsrc = RS_IMM; end
          OP_LW:  begin RegW1 = 1'b1; Regsrc = RS_MEM; end
          OP_IN:  begin RegW1 = 1'b1; Regsrc = RS_IO;  end
          OP_OUT: ioWrite = 1'b1;
          OP_JAL: begin backup = 1'b1; PCWrite = 1'b1; PCsrc = PC_IMM; end
          default: begin RegW1 = 1'b1; Regsrc = RS_ALU; end
        endcase
        state_d = S_FETCH;
      end

      S_CMP: begin
        writeCR = 1'b1;
        cmpeq   = (op_q == OP_BEQ);
        cmpne   = (op_q == OP_BNE);
        state_d = S_BR;
      end

      S_BR: begin
        if (op_q == OP_JR) begin
          restore = 1'b1;
          PCWrite = 1'b1;
          PCsrc   = PC_RA;
        end else begin
          PCWrite = cmp_result;
          PCsrc   = PC_IMM;
        end
        state_d = S_FETCH;
      end

      S_HLT: halted = 1'b1;

      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized bench for control_fsm: each instruction is expanded into its
// expected per-cycle strobe trace, which a negedge monitor checks in order.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] op = '0;
  logic       cmp_result = 1'b0;

  logic       PCWrite, IRWrite, ImRWrite, RegR1, RegR2, RegW1, RegW2;
  logic [1:0] PCsrc, Regsrc;
  logic       ALUsrc;
  logic [2:0] ALUop;
  logic       writeCR, cmpeq, cmpne, backup, restore, ioWrite, halted, fault;

  control_fsm_if mem_if ();

  control_fsm #(.MEM_WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .cmp_result(cmp_result), .mem(mem_if),
    .PCWrite(PCWrite), .PCsrc(PCsrc), .IRWrite(IRWrite), .ImRWrite(ImRWrite),
    .RegR1(RegR1), .RegR2(RegR2), .RegW1(RegW1), .RegW2(RegW2), .Regsrc(Regsrc),
    .ALUsrc(ALUsrc), .ALUop(ALUop), .writeCR(writeCR), .cmpeq(cmpeq), .cmpne(cmpne),
    .backup(backup), .restore(restore), .ioWrite(ioWrite), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       imrw;
    logic       req;
    logic       we;
    logic       iord;
    logic       r1;
    logic       r2;
    logic       w1;
    logic       w2;
    logic [1:0] regsrc;
    logic       alusrc;
    logic [2:0] aluop;
    logic       wcr;
    logic       ceq;
    logic       cne;
    logic       bak;
    logic       rsto;
    logic       iow;
    logic       hlt;
    logic       flt;
  } outs_t;

  typedef struct {
    string tag;
    outs_t exp;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mop;
  outs_t      z = '0;

  function automatic outs_t actual();
    outs_t a;
    a.pcw = PCWrite;   a.pcsrc = PCsrc;    a.irw = IRWrite;     a.imrw = ImRWrite;
    a.req = mem_if.mem_req; a.we = mem_if.mem_we; a.iord = mem_if.iord;
    a.r1 = RegR1;      a.r2 = RegR2;       a.w1 = RegW1;        a.w2 = RegW2;
    a.regsrc = Regsrc; a.alusrc = ALUsrc;  a.aluop = ALUop;
    a.wcr = writeCR;   a.ceq = cmpeq;      a.cne = cmpne;
    a.bak = backup;    a.rsto = restore;   a.iow = ioWrite;
    a.hlt = halted;    a.flt = fault;
    return a;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [25:0] av, ev;
      e  = exp_q.pop_front();
      av = actual();
      ev = e.exp;
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL %s got=%h expected=%h", e.tag, av, ev);
      end
    end
  end

  function automatic logic rb();
    return 1'($urandom());
  endfunction

  // Apply inputs for the current cycle, queue its expected outputs, advance.
  task automatic cyc(input string tag, input logic rst, input logic rdy,
                     input logic cmp, input outs_t e);
    exp_t x;
    reset = rst;
    mem_if.mem_ready = rdy;
    cmp_result = cmp;
    x.tag = tag;
    x.exp = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // kind: 0 instruction fetch, 1 immediate fetch, 2 data memory access.
  task automatic handshake(input int kind, input int waits);
    outs_t e;
    string tag;
    tag = (kind == 0) ? "FETCH" : (kind == 1) ? "FETCH_IMM" : "MEM";
    e = z;
    e.req = 1'b1;
    if (kind == 2) begin
      e.iord = 1'b1;
      e.we   = (mop == OP_SW);
    end
    for (int i = 0; i < waits; i++) cyc({tag, "_wait"}, 1'b0, 1'b0, rb(), e);
    if (kind == 0) begin e.irw = 1'b1;  e.pcw = 1'b1; end
    if (kind == 1) begin e.imrw = 1'b1; e.pcw = 1'b1; end
    cyc({tag, "_done"}, 1'b0, 1'b1, rb(), e);
  endtask

  task automatic front(input logic [3:0] o, input int wf, input int wi);
    outs_t e;
    mop = o;
    op  = o;
    handshake(0, wf);
    if (o >= 4'd5 && o <= 4'd11) handshake(1, wi);
    e = z; e.r1 = 1'b1; e.r2 = 1'b1;
    cyc("DECODE", 1'b0, rb(), rb(), e);
    op = 4'($urandom());
  endtask

  task automatic run_instr(input logic [3:0] o, input logic c,
                           input int wf, input int wi, input int wm);
    outs_t e;
    logic [2:0] f;
    front(o, wf, wi);
    f = o[2:0];
    if (o <= OP_ADDI || o == OP_LW || o == OP_SW) begin
      e = z;
      e.alusrc = (o >= OP_ADDI);
      e.aluop  = (o < OP_ADDI) ? f : 3'b000;
      cyc("EXEC", 1'b0, rb(), rb(), e);
      if (o == OP_LW || o == OP_SW) handshake(2, wm);
      if (o == OP_SW) return;
    end
    if (o == OP_BEQ || o == OP_BNE) begin
      e = z; e.wcr = 1'b1; e.ceq = (o == OP_BEQ); e.cne = (o == OP_BNE);
      cyc("CMP", 1'b0, rb(), rb(), e);
      e = z; e.pcw = c; e.pcsrc = 2'b01;
      cyc("BR_cond", 1'b0, rb(), c, e);
      return;
    end
    if (o == OP_JR) begin
      e = z; e.rsto = 1'b1; e.pcw = 1'b1; e.pcsrc = 2'b10;
      cyc("BR_jr", 1'b0, rb(), rb(), e);
      return;
    end
    e = z;
    case (o)
      OP_LI:   begin e.w1 = 1'b1; e.regsrc = 2'b10; end
      OP_LW:   begin e.w1 = 1'b1; e.regsrc = 2'b11; end
      OP_IN:   begin e.w1 = 1'b1; e.regsrc = 2'b01; end
      OP_OUT:  e.iow = 1'b1;
      OP_JAL:  begin e.bak = 1'b1; e.pcw = 1'b1; e.pcsrc = 2'b01; end
      default: begin e.w1 = 1'b1; e.regsrc = 2'b00; end
    endcase
    cyc("WB", 1'b0, rb(), rb(), e);
  endtask

  initial begin
    outs_t e;
    reset = 1'b1;
    mem_if.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("RST", 1'b0, rb(), rb(), z);

    run_instr(OP_ADD, 1'b0, 0, 0, 0);
    run_instr(OP_ADDI, 1'b0, 0, 0, 0);
    run_instr(OP_LW, 1'b0, 0, 0, 3);
    run_instr(OP_SW, 1'b0, 1, 2, 0);
    run_instr(OP_BEQ, 1'b1, 0, 0, 0);
    run_instr(OP_BEQ, 1'b0, 0, 0, 0);
    run_instr(OP_BNE, 1'b1, 0, 1, 0);
    run_instr(OP_JAL, 1'b0, 0, 0, 0);
    run_instr(OP_JR, 1'b0, 0, 0, 0);
    for (int n = 0; n < 60; n++)
      run_instr(4'($urandom_range(0, 14)), rb(), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 4));

    // Reset lands while the LW data request is still open.
    front(OP_LW, 0, 0);
    e = z; e.alusrc = 1'b1;
    cyc("EXEC_lw", 1'b0, rb(), rb(), e);
    e = z; e.req = 1'b1; e.iord = 1'b1;
    cyc("MEM_at_reset", 1'b1, 1'b0, rb(), e);
    cyc("RST_after_mem", 1'b0, rb(), rb(), z);
    run_instr(OP_ADD, 1'b0, 0, 0, 0);

    // Fetch never answered: 15 request cycles, then sticky fault and halt.
    op = OP_ADD;
    e = z; e.req = 1'b1;
    for (int i = 0; i < 15; i++) cyc("FETCH_stall", 1'b0, 1'b0, rb(), e);
    e = z; e.hlt = 1'b1; e.flt = 1'b1;
    for (int i = 0; i < 6; i++) cyc("HLT_fault", 1'b0, rb(), rb(), e);
    cyc("HLT_at_reset", 1'b1, rb(), rb(), e);
    cyc("RST_after_fault", 1'b0, rb(), rb(), z);
    run_instr(OP_OR, 1'b0, 0, 0, 0);

    // HALT opcode stops the core without a fault.
    front(OP_HALT, 0, 0);
    e = z; e.hlt = 1'b1;
    for (int i = 0; i < 4; i++) cyc("HLT_op", 1'b0, rb(), rb(), e);
    cyc("HLT_op_reset", 1'b1, rb(), rb(), e);
    cyc("RST_final", 1'b0, rb(), rb(), z);

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
